// File: rtl/mux_rr_invert_pkg.sv
// Shared types and helpers for the round-robin inverting mux and its arbiter.
// Channel indices are handled as int in the helpers; callers size-cast the result.
package mux_rr_invert_pkg;

  localparam int DEF_N_CH = 4;
  localparam int DEF_W    = 8;
  localparam int MAX_CH   = 32;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_e;

  // Wrapped increment; correct for any channel count, not only powers of two.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

  function automatic int onehot_to_idx(input logic [MAX_CH-1:0] oh);
    int idx;
    idx = 0;
    for (int i = 0; i < MAX_CH; i++) begin
      if (oh[i]) idx = idx | i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/mux_rr_invert_if.sv
// Producer/consumer handshake bundle for mux_rr_invert; slave is the mux side.
// in_last only exists when MUX_RR_INVERT_LOCK_EN is defined.
interface mux_rr_invert_if import mux_rr_invert_pkg::*; #(
  parameter int N_CH = DEF_N_CH,
  parameter int W    = DEF_W
) ();
  localparam int CH_W = $clog2(N_CH);

  logic [N_CH-1:0]   in_valid;
  logic [N_CH-1:0]   in_ready;
  logic [N_CH*W-1:0] in_data;
  logic [N_CH-1:0]   inv_mask;
`ifdef MUX_RR_INVERT_LOCK_EN
  logic [N_CH-1:0]   in_last;
`endif
  logic              out_valid;
  logic              out_ready;
  logic [W-1:0]      out_data;
  logic [CH_W-1:0]   out_ch;

`ifdef MUX_RR_INVERT_LOCK_EN
  modport slave (
    input  in_valid, in_data, inv_mask, in_last, out_ready,
    output in_ready, out_valid, out_data, out_ch
  );
  modport master (
    output in_valid, in_data, inv_mask, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_ch
  );
`else
  modport slave (
    input  in_valid, in_data, inv_mask, out_ready,
    output in_ready, out_valid, out_data, out_ch
  );
  modport master (
    output in_valid, in_data, inv_mask, out_ready,
    input  in_ready, out_valid, out_data, out_ch
  );
`endif

endinterface

// File: rtl/mux_rr_invert_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first requester at or after ptr.
// Zero latency, no state; the caller owns the pointer.
module rr_arbiter import mux_rr_invert_pkg::*; #(
  parameter int N_CH = DEF_N_CH,
  localparam int PW  = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [N_CH-1:0] grant
);

  logic [N_CH-1:0] grant_hi;
  logic [N_CH-1:0] grant_lo;
  logic            found_hi;
  logic            found_lo;

  // Lowest requester at or above ptr wins; otherwise the search wraps to the lowest overall.
  always_comb begin
    grant_hi = '0;
    grant_lo = '0;
    found_hi = 1'b0;
    found_lo = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (req[i] && (i >= int'(ptr)) && !found_hi) begin
        grant_hi[i] = 1'b1;
        found_hi    = 1'b1;
      end
      if (req[i] && !found_lo) begin
        grant_lo[i] = 1'b1;
        found_lo    = 1'b1;
      end
    end
    grant = found_hi ? grant_hi : grant_lo;
  end

endmodule

// File: rtl/mux_rr_invert.sv
// N-channel round-robin mux with per-channel inversion and a 1-cycle registered output;
// in_ready drops while the output word is stalled. MUX_RR_INVERT_LOCK_EN adds in_last packet locking.
module mux_rr_invert import mux_rr_invert_pkg::*; #(
  parameter int N_CH = DEF_N_CH,
  parameter int W    = DEF_W
) (
  input logic            clk,
  input logic            rst,
  mux_rr_invert_if.slave bus
);
  localparam int CH_W = $clog2(N_CH);

  out_state_e      state_q, state_d;
  logic [W-1:0]    out_data_q, out_data_d;
  logic [CH_W-1:0] out_ch_q, out_ch_d;
  logic [CH_W-1:0] ptr_q, ptr_d;
  logic [N_CH-1:0] req;
  logic [N_CH-1:0] grant;
  logic [N_CH-1:0] in_ready;
  logic [CH_W-1:0] g_idx;
  logic [W-1:0]    sel_dat;
  logic            sel_inv;
  logic            load_en;
  logic            xfer;
`ifdef MUX_RR_INVERT_LOCK_EN
  logic            lock_q, lock_d;
  logic [CH_W-1:0] lock_ch_q, lock_ch_d;
  logic            sel_last;
`endif

  always_comb begin
    req = bus.in_valid;
`ifdef MUX_RR_INVERT_LOCK_EN
    // A locked channel excludes everyone else, even while it is idle.
    if (lock_q) begin
      for (int i = 0; i < N_CH; i++) begin
        req[i] = bus.in_valid[i] && (i == int'(lock_ch_q));
      end
    end
`endif
  end

  rr_arbiter #(.N_CH(N_CH)) u_arb (
    .req   (req),
    .ptr   (ptr_q),
    .grant (grant)
  );

  assign load_en      = (state_q == EMPTY) || bus.out_ready;
  assign in_ready     = grant & {N_CH{load_en && rst}};
  assign xfer         = |in_ready;
  assign g_idx        = CH_W'(onehot_to_idx(MAX_CH'(grant)));
  assign bus.in_ready = in_ready;

  always_comb begin
    sel_dat = '0;
    sel_inv = 1'b0;
`ifdef MUX_RR_INVERT_LOCK_EN
    sel_last = 1'b0;
`endif
    for (int i = 0; i < N_CH; i++) begin
      if (grant[i]) begin
        sel_dat = bus.in_data[i*W +: W];
        sel_inv = bus.inv_mask[i];
`ifdef MUX_RR_INVERT_LOCK_EN
        sel_last = bus.in_last[i];
`endif
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    out_data_d = out_data_q;
    out_ch_d   = out_ch_q;
    ptr_d      = ptr_q;
`ifdef MUX_RR_INVERT_LOCK_EN
    lock_d     = lock_q;
    lock_ch_d  = lock_ch_q;
`endif
    if (load_en) begin
      if (xfer) begin
        state_d    = FULL;
        // Inversion is a data-path mux between true and complemented words.
        out_data_d = sel_inv ? ~sel_dat : sel_dat;
        out_ch_d   = g_idx;
`ifdef MUX_RR_INVERT_LOCK_EN
        if (sel_last) begin
          lock_d = 1'b0;
          ptr_d  = CH_W'(wrap_inc(int'(g_idx), N_CH));
        end else begin
          lock_d    = 1'b1;
          lock_ch_d = g_idx;
        end
`else
        ptr_d      = CH_W'(wrap_inc(int'(g_idx), N_CH));
`endif
      end else begin
        state_d = EMPTY;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= EMPTY;
      out_data_q <= '0;
      out_ch_q   <= '0;
      ptr_q      <= '0;
`ifdef MUX_RR_INVERT_LOCK_EN
      lock_q     <= 1'b0;
      lock_ch_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      out_data_q <= out_data_d;
      out_ch_q   <= out_ch_d;
      ptr_q      <= ptr_d;
`ifdef MUX_RR_INVERT_LOCK_EN
      lock_q     <= lock_d;
      lock_ch_q  <= lock_ch_d;
`endif
    end
  end

  assign bus.out_valid = (state_q == FULL);
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;

endmodule

// File: tb/tb_mux_rr_invert.sv
// Bench for mux_rr_invert: a 4-channel and a 3-channel instance checked against a queue-free
// behavioural model; the lock scenario runs only when MUX_RR_INVERT_LOCK_EN is defined.
module tb_mux_rr_invert;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mux_rr_invert_if #(.N_CH(4), .W(8)) if4 ();
  mux_rr_invert_if #(.N_CH(3), .W(8)) if3 ();

  logic [3:0] last4 = '1;
  logic [2:0] last3 = '1;

`ifdef MUX_RR_INVERT_LOCK_EN
  localparam bit LOCK = 1'b1;
  assign if4.in_last = last4;
  assign if3.in_last = last3;
`else
  localparam bit LOCK = 1'b0;
`endif

  mux_rr_invert #(.N_CH(4), .W(8)) u_dut4 (.clk(clk), .rst(rst), .bus(if4));
  mux_rr_invert #(.N_CH(3), .W(8)) u_dut3 (.clk(clk), .rst(rst), .bus(if3));

  typedef struct {
    bit         vld;
    logic [7:0] dat;
    int         ch;
    int         ptr;
    bit         lock;
    int         lock_ch;
  } model_t;

  model_t m4, m3;
  int total = 0;
  int bad   = 0;

  // Winning channel for this cycle, or -1 when nothing can be accepted.
  function automatic int pick(input model_t m, input int n, input logic [3:0] v, input logic ordy);
    int c;
    if (m.vld && !ordy) return -1;
    for (int k = 0; k < n; k++) begin
      c = (m.ptr + k) % n;
      if (v[c] && (!m.lock || c == m.lock_ch)) return c;
    end
    return -1;
  endfunction

  function automatic model_t advance(input model_t m, input int n, input logic [3:0] v,
                                     input logic [31:0] d, input logic [3:0] inv,
                                     input logic [3:0] last, input logic ordy);
    model_t r;
    int g;
    logic [7:0] w;
    r = m;
    g = pick(m, n, v, ordy);
    if (g >= 0) begin
      w     = d[g*8 +: 8];
      r.vld = 1'b1;
      r.dat = inv[g] ? ~w : w;
      r.ch  = g;
      if (LOCK && !last[g]) begin
        r.lock    = 1'b1;
        r.lock_ch = g;
      end else begin
        r.lock = 1'b0;
        r.ptr  = (g + 1) % n;
      end
    end else if (!m.vld || ordy) begin
      r.vld = 1'b0;
    end
    return r;
  endfunction

  function automatic logic [3:0] rdy_of(input int g);
    logic [3:0] r;
    r = '0;
    if (g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  function automatic int pick4();
    return pick(m4, 4, if4.in_valid, if4.out_ready);
  endfunction

  function automatic int pick3();
    return pick(m3, 3, 4'(if3.in_valid), if3.out_ready);
  endfunction

  task automatic tick();
    m4 = advance(m4, 4, if4.in_valid, if4.in_data, if4.inv_mask, last4, if4.out_ready);
    m3 = advance(m3, 3, 4'(if3.in_valid), 32'(if3.in_data), 4'(if3.inv_mask), 4'(last3),
                 if3.out_ready);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    if4.in_valid = '0; if4.in_data = '0; if4.inv_mask = '0; if4.out_ready = 1'b1;
    if3.in_valid = '0; if3.in_data = '0; if3.inv_mask = '0; if3.out_ready = 1'b1;
    last4 = '1;
    last3 = '1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    m4  = '{default: 0};
    m3  = '{default: 0};
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b0;
    if4.in_valid = '1;
    if3.in_valid = '1;
    if4.in_data  = 32'hA3A2A1A0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (if4.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b exp=0", if4.out_valid); end
    total++; if (if4.in_ready !== 4'b0000) begin bad++; $display("FAIL reset_in_ready got=%b exp=0000", if4.in_ready); end
    total++; if (if4.out_data !== 8'h00 || if4.out_ch !== 2'd0) begin bad++; $display("FAIL reset_out_regs got=%h/%0d exp=00/0", if4.out_data, if4.out_ch); end
    total++; if (if3.in_ready !== 3'b000 || if3.out_valid !== 1'b0) begin bad++; $display("FAIL reset_dut3 got=%b/%0b exp=000/0", if3.in_ready, if3.out_valid); end
    rst = 1'b1;
    m4  = '{default: 0};
    m3  = '{default: 0};
    #1;
    total++; if (if4.in_ready !== 4'b0001) begin bad++; $display("FAIL reset_first_grant got=%b exp=0001", if4.in_ready); end
    total++; if (if3.in_ready !== 3'b001) begin bad++; $display("FAIL reset_first_grant3 got=%b exp=001", if3.in_ready); end
    tick();
    total++; if (if4.out_valid !== 1'b1 || if4.out_ch !== 2'd0 || if4.out_data !== 8'hA0) begin
      bad++; $display("FAIL reset_first_word got=%0b/%0d/%h exp=1/0/a0", if4.out_valid, if4.out_ch, if4.out_data);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    if4.in_valid = 4'b1111;
    if4.in_data  = {8'h13, 8'h12, 8'h11, 8'h10};
    for (int k = 0; k < 5; k++) begin
      #1;
      total++; if (if4.in_ready !== 4'(1 << (k % 4))) begin bad++; $display("FAIL rr_in_ready[%0d] got=%b exp=%b", k, if4.in_ready, 4'(1 << (k % 4))); end
      tick();
      total++; if (if4.out_valid !== 1'b1 || if4.out_ch !== 2'(k % 4) || if4.out_data !== 8'(8'h10 + k % 4)) begin
        bad++; $display("FAIL rr_out[%0d] got=%0b/%0d/%h exp=1/%0d/%h", k, if4.out_valid, if4.out_ch, if4.out_data, k % 4, 8'(8'h10 + k % 4));
      end
    end
  endtask

  task automatic test_inversion();
    do_reset();
    if4.in_valid = 4'b0100;
    if4.in_data  = {8'h00, 8'h3C, 8'h00, 8'h00};
    if4.inv_mask = 4'b0100;
    tick();
    total++; if (if4.out_data !== 8'hC3 || if4.out_ch !== 2'd2) begin bad++; $display("FAIL inv_word got=%h/%0d exp=c3/2", if4.out_data, if4.out_ch); end
    if4.in_valid  = '0;
    if4.out_ready = 1'b0;
    if4.inv_mask  = 4'b0000;
    tick();
    total++; if (if4.out_data !== 8'hC3 || if4.out_valid !== 1'b1) begin bad++; $display("FAIL inv_hold0 got=%h/%0b exp=c3/1", if4.out_data, if4.out_valid); end
    if4.inv_mask = 4'b1111;
    tick();
    total++; if (if4.out_data !== 8'hC3) begin bad++; $display("FAIL inv_hold1 got=%h exp=c3", if4.out_data); end
  endtask

  task automatic test_backpressure();
    do_reset();
    if4.in_valid = 4'b0010;
    if4.in_data  = {8'h00, 8'h00, 8'h55, 8'h00};
    tick();
    if4.in_data   = {8'h00, 8'h00, 8'h66, 8'h00};
    if4.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      total++; if (if4.in_ready !== 4'b0000) begin bad++; $display("FAIL bp_in_ready[%0d] got=%b exp=0000", k, if4.in_ready); end
      tick();
      total++; if (if4.out_data !== 8'h55 || if4.out_ch !== 2'd1 || if4.out_valid !== 1'b1) begin
        bad++; $display("FAIL bp_hold[%0d] got=%h/%0d/%0b exp=55/1/1", k, if4.out_data, if4.out_ch, if4.out_valid);
      end
    end
    if4.out_ready = 1'b1;
    #1;
    total++; if (if4.in_ready !== 4'b0010) begin bad++; $display("FAIL bp_release_ready got=%b exp=0010", if4.in_ready); end
    tick();
    total++; if (if4.out_data !== 8'h66 || if4.out_valid !== 1'b1) begin bad++; $display("FAIL bp_reload got=%h/%0b exp=66/1", if4.out_data, if4.out_valid); end
  endtask

  task automatic test_wrap();
    do_reset();
    if3.in_data  = {8'h22, 8'h21, 8'h20};
    if3.in_valid = 3'b010;
    tick();
    if3.in_valid = 3'b101;
    #1;
    total++; if (if3.in_ready !== 3'b100) begin bad++; $display("FAIL wrap_grant2 got=%b exp=100", if3.in_ready); end
    tick();
    total++; if (if3.out_ch !== 2'd2 || if3.out_data !== 8'h22) begin bad++; $display("FAIL wrap_out2 got=%0d/%h exp=2/22", if3.out_ch, if3.out_data); end
    #1;
    total++; if (if3.in_ready !== 3'b001) begin bad++; $display("FAIL wrap_grant0 got=%b exp=001", if3.in_ready); end
    tick();
    total++; if (if3.out_ch !== 2'd0 || if3.out_data !== 8'h20) begin bad++; $display("FAIL wrap_out0 got=%0d/%h exp=0/20", if3.out_ch, if3.out_data); end
    if3.in_valid = 3'b111;
    #1;
    total++; if (if3.in_ready !== 3'b010) begin bad++; $display("FAIL wrap_next got=%b exp=010", if3.in_ready); end
    tick();
  endtask

`ifdef MUX_RR_INVERT_LOCK_EN
  task automatic test_lock();
    do_reset();
    if4.in_data  = {8'h13, 8'h12, 8'h11, 8'h10};
    if4.in_valid = 4'b0001;
    tick();
    if4.in_valid = 4'b0111;
    last4 = 4'b0000;
    #1;
    total++; if (if4.in_ready !== 4'b0010) begin bad++; $display("FAIL lock_w0_ready got=%b exp=0010", if4.in_ready); end
    tick();
    total++; if (if4.out_ch !== 2'd1) begin bad++; $display("FAIL lock_w0_ch got=%0d exp=1", if4.out_ch); end
    if4.in_valid = 4'b0101;
    #1;
    total++; if (if4.in_ready !== 4'b0000) begin bad++; $display("FAIL lock_idle_ready got=%b exp=0000", if4.in_ready); end
    tick();
    if4.in_valid = 4'b0111;
    for (int k = 1; k < 3; k++) begin
      last4 = (k == 2) ? 4'b0010 : 4'b0000;
      #1;
      total++; if (if4.in_ready !== 4'b0010) begin bad++; $display("FAIL lock_w%0d_ready got=%b exp=0010", k, if4.in_ready); end
      tick();
      total++; if (if4.out_ch !== 2'd1 || if4.out_valid !== 1'b1) begin bad++; $display("FAIL lock_w%0d_ch got=%0d exp=1", k, if4.out_ch); end
    end
    last4 = 4'b1111;
    #1;
    total++; if (if4.in_ready !== 4'b0100) begin bad++; $display("FAIL lock_after_ready got=%b exp=0100", if4.in_ready); end
    tick();
    total++; if (if4.out_ch !== 2'd2) begin bad++; $display("FAIL lock_after_ch got=%0d exp=2", if4.out_ch); end
  endtask
`endif

  task automatic test_async_reset();
    do_reset();
    if4.in_valid = 4'b0100;
    if4.in_data  = 32'h00770000;
    tick();
    if4.out_ready = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    total++; if (if4.out_valid !== 1'b0 || if4.in_ready !== 4'b0000) begin bad++; $display("FAIL areset_drop got=%0b/%b exp=0/0000", if4.out_valid, if4.in_ready); end
    m4 = '{default: 0};
    m3 = '{default: 0};
    @(posedge clk);
    #1;
    rst = 1'b1;
    if4.in_valid  = 4'b1111;
    if4.out_ready = 1'b1;
    #1;
    total++; if (if4.in_ready !== 4'b0001) begin bad++; $display("FAIL areset_ptr got=%b exp=0001", if4.in_ready); end
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if4.in_valid  = 4'($urandom);
      if4.in_data   = $urandom;
      if4.inv_mask  = 4'($urandom);
      if4.out_ready = ($urandom_range(0, 3) != 0);
      if3.in_valid  = 3'($urandom);
      if3.in_data   = 24'($urandom);
      if3.inv_mask  = 3'($urandom);
      if3.out_ready = ($urandom_range(0, 3) != 0);
      last4 = 4'($urandom);
      last3 = 3'($urandom);
      #1;
      total++; if (if4.in_ready !== rdy_of(pick4())) begin bad++; $display("FAIL rand4_ready[%0d] got=%b exp=%b", c, if4.in_ready, rdy_of(pick4())); end
      total++; if (if3.in_ready !== 3'(rdy_of(pick3()))) begin bad++; $display("FAIL rand3_ready[%0d] got=%b exp=%b", c, if3.in_ready, 3'(rdy_of(pick3()))); end
      tick();
      total++; if (if4.out_valid !== m4.vld || if4.out_data !== m4.dat || if4.out_ch !== 2'(m4.ch)) begin
        bad++; $display("FAIL rand4_out[%0d] got=%0b/%h/%0d exp=%0b/%h/%0d", c, if4.out_valid, if4.out_data, if4.out_ch, m4.vld, m4.dat, m4.ch);
      end
      total++; if (if3.out_valid !== m3.vld || if3.out_data !== m3.dat || if3.out_ch !== 2'(m3.ch)) begin
        bad++; $display("FAIL rand3_out[%0d] got=%0b/%h/%0d exp=%0b/%h/%0d", c, if3.out_valid, if3.out_data, if3.out_ch, m3.vld, m3.dat, m3.ch);
      end
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_round_robin();
    test_inversion();
    test_backpressure();
    test_wrap();
`ifdef MUX_RR_INVERT_LOCK_EN
    test_lock();
`endif
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
